// File: rtl/oram_path_ctrl_pkg.sv
// Shared types, defaults and the LFSR step function for the path-ORAM controller.
package oram_path_ctrl_pkg;

    localparam int          DEF_A     = 8;
    localparam int          DEF_D     = 6;
    localparam int          DEF_K     = 3;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } oram_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REMAP,
        ST_SCAN,
        ST_PUTBACK,
        ST_FLUSH,
        ST_RESP
    } oram_ctrl_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/oram_path_ctrl_lfsr.sv
// 16-bit Galois LFSR; advances one step per cycle with step_i high, holds otherwise.
module oram_lfsr
    import oram_path_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/oram_path_ctrl.sv
// Path-ORAM access engine: remap, path scan, root put-back, fixed-length flush; accept->rsp_valid = 24 cycles at D=6 regardless of hit/op.
// req_ready only in IDLE; rsp_valid holds with stable data until rsp_ready.
module oram_path_ctrl
    import oram_path_ctrl_pkg::*;
#(
    parameter int          A    = DEF_A,
    parameter int          D    = DEF_D,
    parameter int          K    = DEF_K,
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_op,
    input  logic [D-1:0]   req_block,
    input  logic [8*A-1:0] req_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [8*A-1:0] rsp_rdata,
    output logic           rsp_hit,
    output logic           overflow
);

    localparam int P     = D - 1;
    localparam int W     = 8 * A;
    localparam int NODES = (1 << D) - 1;
    localparam int NBLK  = 1 << D;
    localparam int LW    = $clog2(D);

    typedef struct packed {
        logic         vld;
        logic [P-1:0] pos;
        logic [D-1:0] num;
        logic [W-1:0] val;
    } tuple_t;

    typedef tuple_t [K-1:0] bucket_t;

    typedef struct packed {
        logic         vld;
        logic [P-1:0] pos;
    } pmap_t;

    oram_ctrl_state_e state_q, state_d;
    oram_op_e         op_q;
    logic [D-1:0]     blk_q;
    logic [W-1:0]     wdata_q, data_q;
    logic [P-1:0]     old_pos_q, new_pos_q, flush_pos_q;
    logic [LW-1:0]    lvl_q, sweep_q;
    logic             hit_q, overflow_q;
    bucket_t          tree_q [NODES];
    pmap_t            pmap_q [NBLK];

    logic             lfsr_step;
    logic [15:0]      lfsr;
    logic             unused_lfsr_hi;

    logic [D-1:0]     scan_idx, up_idx, lo_idx;
    bucket_t          scan_d, root_d, up_d, lo_d;
    logic             scan_hit, root_ok, placed;
    logic [W-1:0]     scan_val;

    oram_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (lfsr_step),
        .state_o (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:P];

    // Heap node (0-based array index) at depth lvl on the path to leaf pos.
    function automatic logic [D-1:0] node_idx(input logic [P-1:0] pos, input int lvl);
        logic [D:0] n;
        n = (D+1)'(1);
        for (int i = 0; i < P; i++) begin
            if (i < lvl) n = {n[D-1:0], pos[i]};
        end
        n = n - (D+1)'(1);
        return n[D-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE:    if (req_valid) state_d = ST_REMAP;
            ST_REMAP: begin
                lfsr_step = !pmap_q[blk_q].vld;
                state_d   = ST_SCAN;
            end
            ST_SCAN: begin
                lfsr_step = (lvl_q == '0);
                if (lvl_q == LW'(D-1)) state_d = ST_PUTBACK;
            end
            ST_PUTBACK: begin
                lfsr_step = 1'b1;
                state_d   = ST_FLUSH;
            end
            ST_FLUSH:   if (lvl_q == LW'(D-2) && sweep_q == '0) state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_idx = node_idx(old_pos_q, int'(lvl_q));
        scan_d   = tree_q[scan_idx];
        scan_hit = 1'b0;
        scan_val = '0;
        for (int k = K - 1; k >= 0; k--) begin
            if (scan_d[k].vld && scan_d[k].num == blk_q && scan_d[k].pos == old_pos_q) begin
                scan_hit     = 1'b1;
                scan_val     = scan_d[k].val;
                scan_d[k].vld = 1'b0;
            end
        end
    end

    always_comb begin
        root_d  = tree_q[0];
        root_ok = 1'b0;
        for (int k = 0; k < K; k++) begin
            if (!root_ok && !root_d[k].vld) begin
                root_d[k] = '{vld: 1'b1, pos: new_pos_q, num: blk_q,
                              val: (op_q == OP_WRITE) ? wdata_q : data_q};
                root_ok   = 1'b1;
            end
        end
    end

    // Greedy push of eligible tuples one level down the flush path.
    always_comb begin
        up_idx = node_idx(flush_pos_q, int'(lvl_q));
        lo_idx = node_idx(flush_pos_q, int'(lvl_q) + 1);
        up_d   = tree_q[up_idx];
        lo_d   = tree_q[lo_idx];
        placed = 1'b0;
        for (int u = 0; u < K; u++) begin
            placed = 1'b0;
            if (up_d[u].vld && up_d[u].pos[lvl_q] == flush_pos_q[lvl_q]) begin
                for (int j = 0; j < K; j++) begin
                    if (!placed && !lo_d[j].vld) begin
                        lo_d[j]      = up_d[u];
                        up_d[u].vld  = 1'b0;
                        placed       = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            blk_q       <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            old_pos_q   <= '0;
            new_pos_q   <= '0;
            flush_pos_q <= '0;
            lvl_q       <= '0;
            sweep_q     <= '0;
            hit_q       <= 1'b0;
            overflow_q  <= 1'b0;
            for (int n = 0; n < NODES; n++) tree_q[n] <= '0;
            for (int b = 0; b < NBLK; b++)  pmap_q[b] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= oram_op_e'(req_op);
                        blk_q   <= req_block;
                        wdata_q <= req_wdata;
                        hit_q   <= 1'b0;
                        data_q  <= '0;
                    end
                end
                ST_REMAP: begin
                    old_pos_q <= pmap_q[blk_q].vld ? pmap_q[blk_q].pos : lfsr[P-1:0];
                    lvl_q     <= '0;
                end
                ST_SCAN: begin
                    if (lvl_q == '0) new_pos_q <= lfsr[P-1:0];
                    if (scan_hit) begin
                        hit_q  <= 1'b1;
                        data_q <= scan_val;
                    end
                    tree_q[scan_idx] <= scan_d;
                    lvl_q            <= lvl_q + LW'(1);
                end
                ST_PUTBACK: begin
                    if (root_ok) begin
                        tree_q[0]     <= root_d;
                        pmap_q[blk_q] <= '{vld: 1'b1, pos: new_pos_q};
                    end else begin
                        pmap_q[blk_q] <= '0;
                        overflow_q    <= 1'b1;
                    end
                    flush_pos_q <= lfsr[P-1:0];
                    sweep_q     <= LW'(D-2);
                    lvl_q       <= LW'(D-2);
                end
                ST_FLUSH: begin
                    tree_q[up_idx] <= up_d;
                    tree_q[lo_idx] <= lo_d;
                    if (lvl_q == LW'(D-2)) begin
                        if (sweep_q != '0) begin
                            sweep_q <= sweep_q - LW'(1);
                            lvl_q   <= sweep_q - LW'(1);
                        end
                    end else begin
                        lvl_q <= lvl_q + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = data_q;
    assign rsp_hit   = hit_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_oram_path_ctrl.sv
// Randomised bench for oram_path_ctrl with an algorithmic path-ORAM reference model and a per-cycle compare process.
module tb_oram_path_ctrl;

    localparam int          A     = 8;
    localparam int          D     = 6;
    localparam int          K     = 3;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          P     = D - 1;
    localparam int          W     = 8 * A;
    localparam int          NODES = (1 << D) - 1;
    localparam int          NBLK  = 1 << D;
    localparam int          LAT   = 1 + D + 1 + D * (D - 1) / 2 + 1;
    localparam int          PH_IDLE = 0, PH_BUSY = 1, PH_RESP = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid, req_ready, req_op;
    logic [D-1:0]   req_block;
    logic [W-1:0]   req_wdata;
    logic           rsp_valid, rsp_ready, rsp_hit, overflow;
    logic [W-1:0]   rsp_rdata;

    always #5 clk = ~clk;

    oram_path_ctrl #(.A(A), .D(D), .K(K), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_block (req_block),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_hit   (rsp_hit),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned  m_lfsr;
    bit           m_pm_vld [NBLK];
    int           m_pm_pos [NBLK];
    bit           m_vld [NODES][K];
    int           m_pos [NODES][K];
    int           m_num [NODES][K];
    logic [W-1:0] m_val [NODES][K];
    bit           m_ovf, m_hit;
    logic [W-1:0] m_rdata;
    int           m_phase, m_cnt;

    function automatic int unsigned lfsr_step(input int unsigned s);
        return (s & 1) ? ((s >> 1) ^ 32'hB400) : (s >> 1);
    endfunction

    function automatic int path_node(input int pos, input int lvl);
        int n;
        n = 1;
        for (int i = 0; i < lvl; i++) n = 2 * n + ((pos >> i) & 1);
        return n - 1;
    endfunction

    task automatic draw(output int v);
        v      = int'(m_lfsr & ((1 << P) - 1));
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic model_reset();
        m_lfsr  = {16'h0, SEED};
        m_ovf   = 0;
        m_hit   = 0;
        m_rdata = '0;
        m_phase = PH_IDLE;
        m_cnt   = 0;
        for (int b = 0; b < NBLK; b++) begin
            m_pm_vld[b] = 0;
            m_pm_pos[b] = 0;
        end
        for (int n = 0; n < NODES; n++)
            for (int k = 0; k < K; k++) m_vld[n][k] = 0;
    endtask

    task automatic model_access(input bit op, input int blk, input logic [W-1:0] wd);
        int oldp, newp, fp, nd, up, lo;
        bit found, placed;
        logic [W-1:0] v;
        if (m_pm_vld[blk]) oldp = m_pm_pos[blk];
        else draw(oldp);
        draw(newp);
        m_hit   = 0;
        m_rdata = '0;
        for (int l = 0; l < D; l++) begin
            nd = path_node(oldp, l);
            for (int k = 0; k < K; k++)
                if (m_vld[nd][k] && m_num[nd][k] == blk && m_pos[nd][k] == oldp) begin
                    m_hit       = 1;
                    m_rdata     = m_val[nd][k];
                    m_vld[nd][k] = 0;
                end
        end
        v     = op ? wd : m_rdata;
        found = 0;
        for (int k = 0; k < K; k++)
            if (!found && !m_vld[0][k]) begin
                found      = 1;
                m_vld[0][k] = 1;
                m_pos[0][k] = newp;
                m_num[0][k] = blk;
                m_val[0][k] = v;
            end
        if (found) begin
            m_pm_vld[blk] = 1;
            m_pm_pos[blk] = newp;
        end else begin
            m_pm_vld[blk] = 0;
            m_ovf         = 1;
        end
        draw(fp);
        for (int s = D - 2; s >= 0; s--)
            for (int l = s; l <= D - 2; l++) begin
                up = path_node(fp, l);
                lo = path_node(fp, l + 1);
                for (int u = 0; u < K; u++)
                    if (m_vld[up][u] && ((m_pos[up][u] >> l) & 1) == ((fp >> l) & 1)) begin
                        placed = 0;
                        for (int j = 0; j < K; j++)
                            if (!placed && !m_vld[lo][j]) begin
                                m_vld[lo][j] = 1;
                                m_pos[lo][j] = m_pos[up][u];
                                m_num[lo][j] = m_num[up][u];
                                m_val[lo][j] = m_val[up][u];
                                m_vld[up][u] = 0;
                                placed       = 1;
                            end
                    end
            end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    check_b("idle_req_ready", req_ready, 1'b1);
                    check_b("idle_rsp_valid", rsp_valid, 1'b0);
                    check_b("idle_overflow", overflow, m_ovf);
                    if (req_valid) begin
                        model_access(req_op, int'(req_block), req_wdata);
                        m_cnt   = LAT - 1;
                        m_phase = PH_BUSY;
                    end
                end
                PH_BUSY: begin
                    check_b("busy_req_ready", req_ready, 1'b0);
                    check_b("busy_rsp_valid", rsp_valid, 1'b0);
                    m_cnt--;
                    if (m_cnt == 0) m_phase = PH_RESP;
                end
                default: begin
                    check_b("resp_rsp_valid", rsp_valid, 1'b1);
                    check_b("resp_req_ready", req_ready, 1'b0);
                    check_b("resp_hit", rsp_hit, m_hit);
                    check_v("resp_rdata", rsp_rdata, m_rdata);
                    check_b("resp_overflow", overflow, m_ovf);
                    if (rsp_ready) m_phase = PH_IDLE;
                end
            endcase
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input bit op, input logic [D-1:0] blk, input logic [W-1:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_block = blk;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(input int stall, output logic hit, output logic [W-1:0] rd, output int lat);
        lat       = 0;
        rsp_ready = (stall == 0);
        while (!rsp_valid && lat < 4 * LAT) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, want %0d", lat, LAT);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
        hit = rsp_hit;
        rd  = rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_b("stall_rsp_valid", rsp_valid, 1'b1);
            check_b("stall_req_ready", req_ready, 1'b0);
            check_v("stall_rdata", rsp_rdata, rd);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic access(input bit op, input logic [D-1:0] blk, input logic [W-1:0] wd,
                          input int stall, output logic hit, output logic [W-1:0] rd, output int lat);
        issue(op, blk, wd);
        collect(stall, hit, rd, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         hit;
        logic [W-1:0] rd;
        int           lat;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_block = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Hand-computed anchors for the model's LFSR and heap walk
        check_i("model_lfsr_step1", int'(lfsr_step(32'hACE1)), 32'hE270);
        check_i("model_lfsr_step2", int'(lfsr_step(lfsr_step(32'hACE1))), 32'h7138);
        check_i("model_path_lvl1", path_node(1, 1), 2);
        check_i("model_path_leaf", path_node(1, 5), 47);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_b("reset_req_ready", req_ready, 1'b1);
        check_b("reset_overflow", overflow, 1'b0);
        check_b("reset_rsp_valid", rsp_valid, 1'b0);
        check_b("reset_rsp_hit", rsp_hit, 1'b0);
        check_v("reset_rsp_rdata", rsp_rdata, '0);

        access(1'b0, 6'd5, '0, 0, hit, rd, lat);
        check_b("read5_miss", hit, 1'b0);
        check_v("read5_rdata", rd, '0);
        check_i("read5_latency", lat, 24);

        access(1'b1, 6'd3, 64'h1122334455667788, 0, hit, rd, lat);
        check_b("write3_miss", hit, 1'b0);
        check_i("write3_latency", lat, 24);
        access(1'b0, 6'd3, '0, 0, hit, rd, lat);
        check_b("read3_hit", hit, 1'b1);
        check_v("read3_rdata", rd, 64'h1122334455667788);

        access(1'b1, 6'd7, 64'hAAAA00001234ABCD, 0, hit, rd, lat);
        access(1'b1, 6'd7, 64'hBBBB0000FEDC5678, 0, hit, rd, lat);
        check_b("write7b_hit", hit, 1'b1);
        check_v("write7b_rdata", rd, 64'hAAAA00001234ABCD);
        access(1'b0, 6'd7, '0, 0, hit, rd, lat);
        check_b("read7_hit", hit, 1'b1);
        check_v("read7_rdata", rd, 64'hBBBB0000FEDC5678);

        access(1'b0, 6'd3, '0, 10, hit, rd, lat);
        check_b("stall_read3_hit", hit, 1'b1);
        check_v("stall_read3_rdata", rd, 64'h1122334455667788);

        repeat (60) begin
            access(1'($urandom_range(0, 1)), D'($urandom_range(0, 15)),
                   {$urandom, $urandom}, $urandom_range(0, 2), hit, rd, lat);
            check_i("rand_latency", lat, LAT);
        end

        for (int b = 0; b < NBLK; b++) access(1'b1, D'(b), W'(b), 0, hit, rd, lat);
        for (int b = 0; b < NBLK; b++) begin
            access(1'b0, D'(b), '0, 0, hit, rd, lat);
            if (hit) check_v("fill_readback", rd, W'(b));
            else     check_b("fill_miss_needs_overflow", overflow, 1'b1);
        end

        access(1'b1, 6'd9, 64'h0909090909090909, 0, hit, rd, lat);
        issue(1'b1, 6'd12, 64'h1212121212121212);
        repeat (11) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_b("midreset_req_ready", req_ready, 1'b1);
        check_b("midreset_overflow", overflow, 1'b0);
        access(1'b0, 6'd9, '0, 0, hit, rd, lat);
        check_b("midreset_read9_miss", hit, 1'b0);
        check_v("midreset_read9_rdata", rd, '0);
        check_b("midreset_read9_overflow", overflow, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
